frame_buffer_manager: RTL

- Parametrised N-buffer (2..4) frame-store controller in the clk_100Mhz AXI domain.
- Replaces the ad-hoc double-buffer swap register in the top level.
- Tracks which DDR frame buffer the AXI writer fills, which one the AXI reader displays, and which completed frame is pending.
- Swaps only on display vsync, drops or repeats frames when camera and display rates differ, and supplies base addresses to both masters.

---
 rtl/fb_pkg.sv | 16 +
 rtl/frame_buffer_manager_free_select.sv | 18 +
 rtl/frame_buffer_manager.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared constants and helpers for the frame-buffer manager.
package fb_pkg;

    localparam int unsigned FRAME_W         = 640;
    localparam int unsigned FRAME_H         = 480;
    localparam int unsigned BYTES_PER_PIX   = 2;
    localparam int unsigned FRAME_BYTES_DEF = FRAME_W * FRAME_H * BYTES_PER_PIX;
    localparam int unsigned BUF_IDX_W       = 2;
    localparam logic [31:0] BASE_ADDR_DEF   = 32'h1000_0000;

    // Increment that holds at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/frame_buffer_manager_free_select.sv
// Picks the lowest buffer index whose bit is clear in the in-use mask.
import fb_pkg::*;

module fb_free_select #(
    parameter int unsigned NUM_BUFS = 3
) (
    input  logic [NUM_BUFS-1:0]  in_use,
    output logic [BUF_IDX_W-1:0] free_idx_c
);

    always_comb begin
        free_idx_c = '0;
        for (int i = int'(NUM_BUFS) - 1; i >= 0; i--) begin
            if (!in_use[i]) free_idx_c = BUF_IDX_W'(i);
        end
    end

endmodule

// File: rtl/frame_buffer_manager.sv
// N-buffer frame-store controller: rotates writer/pending/display roles on
// writer_done and display vsync, and publishes DDR base addresses.
import fb_pkg::*;

module frame_buffer_manager #(
    parameter int unsigned       NUM_BUFS    = 3,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(BASE_ADDR_DEF),
    parameter int unsigned       FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk_100Mhz,
    input  logic              rst,
    input  logic              writer_done,
    input  logic              vsync_start,
    output logic [ADDR_W-1:0] wr_base_addr,
    output logic [ADDR_W-1:0] rd_base_addr,
    output logic [1:0]        wr_buf_idx,
    output logic [1:0]        rd_buf_idx,
    output logic              wr_hold,
    output logic              swap_pulse,
    output logic              drop_pulse,
    output logic              proto_err,
    output logic [CNT_W-1:0]  frames_written,
    output logic [CNT_W-1:0]  frames_dropped,
    output logic [CNT_W-1:0]  frames_repeated
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    function automatic logic [ADDR_W-1:0] addr_of(input logic [BUF_IDX_W-1:0] idx);
        return BASE_ADDR + ADDR_W'(idx) * ADDR_W'(FRAME_BYTES);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), CNT_MAX));
    endfunction

    logic [BUF_IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, pend_idx_q, pend_idx_d;
    logic                 pend_valid_q, pend_valid_d, wr_hold_q, wr_hold_d;
    logic                 swap_q, swap_d, drop_q, drop_d, proto_err_q, proto_err_d;
    logic [CNT_W-1:0]     written_q, written_d, dropped_q, dropped_d, repeated_q, repeated_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [NUM_BUFS-1:0]  in_use_c;
    logic [BUF_IDX_W-1:0] free_idx_c;
    logic                 wd_ok_c;

    // Only consulted on writer_done alone, where the old write buffer becomes pending.
    assign in_use_c = (NUM_BUFS'(1) << rd_idx_q) | (NUM_BUFS'(1) << wr_idx_q);

    fb_free_select #(.NUM_BUFS(NUM_BUFS)) u_free_select (
        .in_use     (in_use_c),
        .free_idx_c (free_idx_c)
    );

    always_comb begin
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        pend_idx_d   = pend_idx_q;
        pend_valid_d = pend_valid_q;
        wr_hold_d    = wr_hold_q;
        swap_d       = 1'b0;
        drop_d       = 1'b0;
        proto_err_d  = proto_err_q;
        written_d    = written_q;
        dropped_d    = dropped_q;
        repeated_d   = repeated_q;
        wd_ok_c      = writer_done && !wr_hold_q;

        if (NUM_BUFS == 2) begin
            if (writer_done && wr_hold_q) proto_err_d = 1'b1;
            if (wd_ok_c && vsync_start) begin
                rd_idx_d     = wr_idx_q;
                wr_idx_d     = rd_idx_q;
                pend_valid_d = 1'b0;
                wr_hold_d    = 1'b0;
                swap_d       = 1'b1;
                written_d    = cnt_inc(written_q);
            end else if (wd_ok_c) begin
                // Writer keeps pointing at the completed frame but is held off it.
                pend_idx_d   = wr_idx_q;
                pend_valid_d = 1'b1;
                wr_hold_d    = 1'b1;
                written_d    = cnt_inc(written_q);
            end else if (vsync_start) begin
                if (pend_valid_q) begin
                    rd_idx_d     = pend_idx_q;
                    wr_idx_d     = rd_idx_q;
                    pend_valid_d = 1'b0;
                    wr_hold_d    = 1'b0;
                    swap_d       = 1'b1;
                end else begin
                    repeated_d = cnt_inc(repeated_q);
                end
            end
        end else begin
            if (writer_done && vsync_start) begin
                rd_idx_d     = wr_idx_q;
                wr_idx_d     = rd_idx_q;
                swap_d       = 1'b1;
                pend_valid_d = 1'b0;
                written_d    = cnt_inc(written_q);
                if (pend_valid_q) begin
                    drop_d    = 1'b1;
                    dropped_d = cnt_inc(dropped_q);
                end
            end else if (writer_done) begin
                if (pend_valid_q) begin
                    drop_d    = 1'b1;
                    dropped_d = cnt_inc(dropped_q);
                end
                pend_idx_d   = wr_idx_q;
                pend_valid_d = 1'b1;
                wr_idx_d     = free_idx_c;
                written_d    = cnt_inc(written_q);
            end else if (vsync_start) begin
                if (pend_valid_q) begin
                    rd_idx_d     = pend_idx_q;
                    pend_valid_d = 1'b0;
                    swap_d       = 1'b1;
                end else begin
                    repeated_d = cnt_inc(repeated_q);
                end
            end
        end

        wr_addr_d = addr_of(wr_idx_d);
        rd_addr_d = addr_of(rd_idx_d);
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            wr_idx_q     <= BUF_IDX_W'(0);
            rd_idx_q     <= BUF_IDX_W'(1);
            pend_idx_q   <= '0;
            pend_valid_q <= 1'b0;
            wr_hold_q    <= 1'b0;
            swap_q       <= 1'b0;
            drop_q       <= 1'b0;
            proto_err_q  <= 1'b0;
            written_q    <= '0;
            dropped_q    <= '0;
            repeated_q   <= '0;
            wr_addr_q    <= addr_of(BUF_IDX_W'(0));
            rd_addr_q    <= addr_of(BUF_IDX_W'(1));
        end else begin
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            pend_idx_q   <= pend_idx_d;
            pend_valid_q <= pend_valid_d;
            wr_hold_q    <= wr_hold_d;
            swap_q       <= swap_d;
            drop_q       <= drop_d;
            proto_err_q  <= proto_err_d;
            written_q    <= written_d;
            dropped_q    <= dropped_d;
            repeated_q   <= repeated_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    assign wr_base_addr    = wr_addr_q;
    assign rd_base_addr    = rd_addr_q;
    assign wr_buf_idx      = wr_idx_q;
    assign rd_buf_idx      = rd_idx_q;
    assign wr_hold         = wr_hold_q;
    assign swap_pulse      = swap_q;
    assign drop_pulse      = drop_q;
    assign proto_err       = proto_err_q;
    assign frames_written  = written_q;
    assign frames_dropped  = dropped_q;
    assign frames_repeated = repeated_q;

    // Role invariants; with two buffers the pending frame still sits under the held writer.
    a_wr_ne_rd: assert property (@(posedge clk_100Mhz) disable iff (rst) wr_idx_q != rd_idx_q);
    a_pend_ok: assert property (@(posedge clk_100Mhz) disable iff (rst)
        pend_valid_q |-> (pend_idx_q != rd_idx_q && (NUM_BUFS == 2 || pend_idx_q != wr_idx_q)));
    a_idx_range: assert property (@(posedge clk_100Mhz) disable iff (rst)
        32'(wr_idx_q) < NUM_BUFS && 32'(rd_idx_q) < NUM_BUFS && 32'(pend_idx_q) < NUM_BUFS);

endmodule
